programa_alu: RTL and testbench

PROGRAMA_ALU -- requirements
Module: programa_alu

---
 rtl/programa_alu.sv | 39 +++
 tb/tb_programa_alu.sv | 115 +++++++++++
 2 files changed

// File: rtl/programa_alu.sv
// programa_alu: switch-loaded A/B/opcode registers feeding an 8-bit ALU with a registered LED result
module programa_alu (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] switch_i,
  input  logic [2:0] bot_i,
  output logic [7:0] led_o
);
  logic [7:0] a_q, a_d, b_q, b_d, led_q, led_d;
  logic [5:0] op_q, op_d;
  always_comb begin
    a_d   = bot_i[0] ? switch_i : a_q;
    b_d   = bot_i[1] ? switch_i : b_q;
    op_d  = bot_i[2] ? switch_i[5:0] : op_q;
    // shifts use all 8 bits of B, so amounts >= 8 saturate to zero or sign fill
    led_d = op_q == 6'b100000 ? a_q + b_q :
            op_q == 6'b100010 ? a_q - b_q :
            op_q == 6'b100100 ? a_q & b_q :
            op_q == 6'b100101 ? a_q | b_q :
            op_q == 6'b100110 ? a_q ^ b_q :
            op_q == 6'b100111 ? ~(a_q | b_q) :
            op_q == 6'b000011 ? 8'($signed(a_q) >>> b_q) :
            op_q == 6'b000010 ? a_q >> b_q : 8'h00;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      op_q  <= 6'h00;
      led_q <= 8'h00;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      led_q <= led_d;
    end
  end
  assign led_o = led_q;
endmodule

// File: tb/tb_programa_alu.sv
// tb_programa_alu: table-driven opcode vectors plus reset/strobe sequences, checked through a scoreboard queue
module tb_programa_alu;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw  = 8'h00;
  logic [2:0] bot = 3'b000;
  logic [7:0] led;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  typedef struct {
    string      nm;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[17];
  programa_alu dut (
    .clk_i(clk),
    .rst_i(rst),
    .switch_i(sw),
    .bot_i(bot),
    .led_o(led)
  );
  always #5 clk = ~clk;
  task automatic load(input logic [7:0] v, input logic [2:0] s);
    @(negedge clk);
    sw  = v;
    bot = s;
    @(negedge clk);
    bot = 3'b000;
  endtask
  task automatic check(input string nm);
    logic [7:0] e;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (led !== e) begin
      errors++;
      $display("FAIL %s: led=%h expected=%h", nm, led, e);
    end
  endtask
  initial begin
    vecs = '{
      '{"add",      8'h0B, 8'h01, 8'h20, 8'h0C},
      '{"sub",      8'h0B, 8'h01, 8'h22, 8'h0A},
      '{"and",      8'h0B, 8'h01, 8'h24, 8'h01},
      '{"or",       8'h0B, 8'h01, 8'h25, 8'h0B},
      '{"xor",      8'h0B, 8'h01, 8'h26, 8'h0A},
      '{"sra",      8'h0B, 8'h01, 8'h03, 8'h05},
      '{"srl",      8'h0B, 8'h01, 8'h02, 8'h05},
      '{"nor",      8'h0B, 8'h01, 8'h27, 8'hF4},
      '{"sra_neg",  8'h90, 8'h02, 8'h03, 8'hE4},
      '{"srl_neg",  8'h90, 8'h02, 8'h02, 8'h24},
      '{"sra_big",  8'h90, 8'h09, 8'h03, 8'hFF},
      '{"srl_big",  8'h90, 8'h09, 8'h02, 8'h00},
      '{"sra_bigp", 8'h70, 8'hFF, 8'h03, 8'h00},
      '{"add_wrap", 8'hFF, 8'h01, 8'h20, 8'h00},
      '{"sub_wrap", 8'h00, 8'h01, 8'h22, 8'hFF},
      '{"illegal",  8'h0B, 8'h01, 8'h3F, 8'h00},
      '{"op_hibits",8'h0B, 8'h01, 8'hE0, 8'h0C}
    };
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(8'h00);
    check("reset");
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h00);
    check("op0_after_reset");
    for (int i = 0; i < 17; i++) begin
      load(vecs[i].a, 3'b001);
      load(vecs[i].b, 3'b010);
      load(vecs[i].op, 3'b100);
      exp_q.push_back(vecs[i].exp);
      check(vecs[i].nm);
    end
    load(8'h05, 3'b011);
    load(8'h20, 3'b100);
    exp_q.push_back(8'h0A);
    check("dual_load");
    @(negedge clk);
    bot = 3'b001;
    sw  = 8'h01;
    @(negedge clk);
    sw  = 8'h02;
    @(negedge clk);
    sw  = 8'h03;
    @(negedge clk);
    bot = 3'b000;
    load(8'h00, 3'b010);
    exp_q.push_back(8'h03);
    check("level_reload");
    load(8'h0B, 3'b001);
    load(8'h01, 3'b010);
    exp_q.push_back(8'h0C);
    check("pre_reset_add");
    sw  = 8'h55;
    bot = 3'b001;
    rst = 1'b1;
    exp_q.push_back(8'h00);
    check("reset_mid_op");
    rst = 1'b0;
    bot = 3'b000;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h00);
    check("idle_after_reset");
    load(8'h01, 3'b010);
    load(8'h20, 3'b100);
    exp_q.push_back(8'h01);
    check("a_not_loaded");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
